// File: rtl/edge_filter_ctrl.sv
// Sequencer in front of edge_filter: registers the pixel stream, tracks x/y,
// owns freq_flag (changed only on start-of-packet) and flags malformed frames.
module edge_filter_ctrl #(
  parameter int IMG_WIDTH       = 320,
  parameter int IMG_LENGTH      = 240,
  parameter int FRAMES_PER_MODE = 60,
  parameter int NUM_MODES       = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  req_flag,
  input  logic        req_valid,
  input  logic        auto_en,
  input  logic        err_clr,
  input  logic        snk_valid,
  input  logic        snk_sop,
  input  logic        snk_eop,
  input  logic [11:0] snk_data,
  output logic        snk_ready,
  output logic        src_valid,
  output logic        src_sop,
  output logic        src_eop,
  output logic [11:0] src_data,
  input  logic        src_ready,
  output logic [2:0]  freq_flag,
  output logic        frame_done,
  output logic        err_sticky,
  output logic [15:0] frame_count,
  output logic        dbg_state
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_LENGTH > 1) ? $clog2(IMG_LENGTH) : 1;
  localparam int CW = $clog2(FRAMES_PER_MODE + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_LENGTH - 1);
  localparam logic [CW-1:0] C_LAST = CW'(FRAMES_PER_MODE - 1);
  localparam logic [2:0]    M_LAST = 3'(NUM_MODES - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  // Handshake: a beat moves on snk when snk_valid && snk_ready, and on src when
  // src_valid && src_ready; src_* hold while src_valid && !src_ready.
  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, pos_x;
  logic [YW-1:0]   y_q, y_d, pos_y;
  logic [CW-1:0]   auto_cnt_q, auto_cnt_d;
  logic [2:0]      pending_q, pending_d;
  logic [2:0]      freq_flag_q, freq_flag_d;
  logic            src_valid_q, src_valid_d;
  logic            src_sop_q, src_sop_d;
  logic            src_eop_q, src_eop_d;
  logic [11:0]     src_data_q, src_data_d;
  logic            frame_done_q, frame_done_d;
  logic            err_q, err_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic            accept, load, frame_ok, err_set, adv, at_eol, at_last;

  assign snk_ready = src_ready || !src_valid_q;

  always_comb begin
    accept   = snk_valid && snk_ready;
    // A sop always restarts the position at (0,0).
    pos_x    = (state_q == ACTIVE && !snk_sop) ? x_q : '0;
    pos_y    = (state_q == ACTIVE && !snk_sop) ? y_q : '0;
    at_eol   = (pos_x == X_LAST);
    at_last  = at_eol && (pos_y == Y_LAST);
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    load     = 1'b0;
    frame_ok = 1'b0;
    err_set  = 1'b0;
    if (accept && (snk_sop || state_q == ACTIVE)) begin
      load = 1'b1;
      if (snk_sop && state_q == ACTIVE) err_set = 1'b1;
      if (snk_eop || at_last) begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
        if (snk_eop && at_last) frame_ok = 1'b1;
        else                    err_set  = 1'b1;
      end else begin
        state_d = ACTIVE;
        if (at_eol) begin
          x_d = '0;
          y_d = pos_y + 1'b1;
        end else begin
          x_d = pos_x + 1'b1;
          y_d = pos_y;
        end
      end
    end
  end

  always_comb begin
    src_valid_d   = load ? 1'b1 : (src_ready ? 1'b0 : src_valid_q);
    src_sop_d     = load ? snk_sop  : src_sop_q;
    src_eop_d     = load ? snk_eop  : src_eop_q;
    src_data_d    = load ? snk_data : src_data_q;
    freq_flag_d   = (load && snk_sop) ? pending_q : freq_flag_q;
    frame_done_d  = frame_ok;
    frame_count_d = frame_ok ? frame_count_q + 16'd1 : frame_count_q;
    err_d         = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    auto_cnt_d    = auto_cnt_q;
    adv           = 1'b0;
    if (!auto_en) begin
      auto_cnt_d = '0;
    end else if (frame_ok) begin
      if (auto_cnt_q == C_LAST) begin
        auto_cnt_d = '0;
        adv        = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + 1'b1;
      end
    end
    // A legal manual request overrides an auto advance in the same cycle.
    pending_d = pending_q;
    if (req_valid && int'(req_flag) < NUM_MODES) pending_d = req_flag;
    else if (adv) pending_d = (freq_flag_q == M_LAST) ? 3'd0 : freq_flag_q + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      auto_cnt_q    <= '0;
      pending_q     <= '0;
      freq_flag_q   <= '0;
      src_valid_q   <= 1'b0;
      src_sop_q     <= 1'b0;
      src_eop_q     <= 1'b0;
      src_data_q    <= '0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      auto_cnt_q    <= auto_cnt_d;
      pending_q     <= pending_d;
      freq_flag_q   <= freq_flag_d;
      src_valid_q   <= src_valid_d;
      src_sop_q     <= src_sop_d;
      src_eop_q     <= src_eop_d;
      src_data_q    <= src_data_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign src_valid   = src_valid_q;
  assign src_sop     = src_sop_q;
  assign src_eop     = src_eop_q;
  assign src_data    = src_data_q;
  assign freq_flag   = freq_flag_q;
  assign frame_done  = frame_done_q;
  assign err_sticky  = err_q;
  assign frame_count = frame_count_q;
  assign dbg_state   = (state_q == ACTIVE);

endmodule

// File: tb/tb_edge_filter_ctrl.sv
// Directed bench for edge_filter_ctrl on a 4x3 frame with 2 frames per mode;
// a scoreboard checks every output beat in order and stall stability.
module tb_edge_filter_ctrl;

  localparam int W   = 4;
  localparam int L   = 3;
  localparam int FPM = 2;
  localparam int NB  = W * L;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_flag;
  logic        req_valid, auto_en, err_clr;
  logic        snk_valid, snk_sop, snk_eop;
  logic [11:0] snk_data;
  logic        snk_ready;
  logic        src_valid, src_sop, src_eop;
  logic [11:0] src_data;
  logic        src_ready;
  logic [2:0]  freq_flag;
  logic        frame_done, err_sticky;
  logic [15:0] frame_count;
  logic        dbg_state;

  int vectors    = 0;
  int miscompares = 0;
  int done_seen  = 0;
  int exp_count  = 0;
  logic        stall_en = 1'b0;
  logic        stall_hold = 1'b0;
  logic [13:0] hold_beat;
  logic [13:0] mon_exp;
  logic [13:0] exp_q[$];

  edge_filter_ctrl #(
    .IMG_WIDTH(W), .IMG_LENGTH(L), .FRAMES_PER_MODE(FPM), .NUM_MODES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_flag(req_flag), .req_valid(req_valid),
    .auto_en(auto_en), .err_clr(err_clr), .snk_valid(snk_valid),
    .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_data(snk_data),
    .snk_ready(snk_ready), .src_valid(src_valid), .src_sop(src_sop),
    .src_eop(src_eop), .src_data(src_data), .src_ready(src_ready),
    .freq_flag(freq_flag), .frame_done(frame_done), .err_sticky(err_sticky),
    .frame_count(frame_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // src_ready pattern: high one cycle in three while stall_en is set
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
        phase++;
        src_ready = (phase % 3 == 0);
      end
    end
  end

  // scoreboard: output beats in order, and held stable while stalled
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_seen++;
    if (reset_n === 1'b1) begin
      if (stall_hold) begin
        vectors++;
        if (src_valid !== 1'b1 || {src_sop, src_eop, src_data} !== hold_beat) begin
          miscompares++;
          $display("FAIL stall_hold got v=%0b beat=%h required v=1 beat=%h",
                   src_valid, {src_sop, src_eop, src_data}, hold_beat);
        end
      end
      if (src_valid === 1'b1 && src_ready === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat got %h required none", {src_sop, src_eop, src_data});
        end else begin
          mon_exp = exp_q.pop_front();
          if ({src_sop, src_eop, src_data} !== mon_exp) begin
            miscompares++;
            $display("FAIL beat_order got %h required %h", {src_sop, src_eop, src_data}, mon_exp);
          end
        end
      end
      stall_hold = (src_valid === 1'b1) && (src_ready === 1'b0);
      hold_beat  = {src_sop, src_eop, src_data};
    end else begin
      stall_hold = 1'b0;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic e, input logic [11:0] d, input logic fwd);
    int guard;
    snk_valid = 1'b1;
    snk_sop   = s;
    snk_eop   = e;
    snk_data  = d;
    guard     = 0;
    @(negedge clk);
    while (snk_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (snk_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_timeout snk_ready=%b required 1", snk_ready);
    end else if (fwd) begin
      exp_q.push_back({s, e, d});
    end
    @(posedge clk);
    #1;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] base);
    for (int i = 0; i < NB; i++) send(i == 0, i == NB - 1, base + 12'(i), 1'b1);
  endtask

  task automatic pulse_req(input logic [2:0] f);
    req_flag  = f;
    req_valid = 1'b1;
    idle(1);
    req_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    idle(1);
  endtask

  // tests
  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    vectors += 8;
    if (src_valid !== 1'b0)    begin miscompares++; $display("FAIL rst_src_valid got %b required 0", src_valid); end
    if (src_sop !== 1'b0 || src_eop !== 1'b0) begin miscompares++; $display("FAIL rst_sop_eop got %b%b required 00", src_sop, src_eop); end
    if (src_data !== 12'h000)  begin miscompares++; $display("FAIL rst_src_data got %h required 000", src_data); end
    if (freq_flag !== 3'd0)    begin miscompares++; $display("FAIL rst_freq got %0d required 0", freq_flag); end
    if (frame_done !== 1'b0)   begin miscompares++; $display("FAIL rst_done got %b required 0", frame_done); end
    if (err_sticky !== 1'b0)   begin miscompares++; $display("FAIL rst_err got %b required 0", err_sticky); end
    if (frame_count !== 16'd0) begin miscompares++; $display("FAIL rst_count got %0d required 0", frame_count); end
    if (snk_ready !== 1'b1 || dbg_state !== 1'b0) begin miscompares++; $display("FAIL rst_ready_state got %b%b required 10", snk_ready, dbg_state); end
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_frame();
    int d0;
    d0 = done_seen;
    send(1'b1, 1'b0, 12'h100, 1'b1);
    @(negedge clk);
    vectors++;
    if (src_valid !== 1'b1 || src_sop !== 1'b1 || src_data !== 12'h100 || dbg_state !== 1'b1) begin
      miscompares++;
      $display("FAIL first_beat_latency got v=%b sop=%b d=%h st=%b required 1 1 100 1", src_valid, src_sop, src_data, dbg_state);
    end
    idle(1);
    for (int i = 1; i < NB; i++) send(1'b0, i == NB - 1, 12'h100 + 12'(i), 1'b1);
    exp_count++;
    @(negedge clk);
    vectors += 2;
    if (frame_done !== 1'b1) begin miscompares++; $display("FAIL done_pulse got %b required 1", frame_done); end
    if (frame_count !== 16'(exp_count)) begin miscompares++; $display("FAIL frame_count got %0d required %0d", frame_count, exp_count); end
    @(negedge clk);
    vectors += 2;
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL done_width got %b required 0", frame_done); end
    if (err_sticky !== 1'b0 || dbg_state !== 1'b0) begin miscompares++; $display("FAIL frame_err_state got %b%b required 00", err_sticky, dbg_state); end
    idle(1);
    vectors++;
    if (done_seen - d0 !== 1) begin miscompares++; $display("FAIL done_once got %0d required 1", done_seen - d0); end
  endtask

  task automatic test_mode_req();
    for (int i = 0; i < NB; i++) begin
      send(i == 0, i == NB - 1, 12'h200 + 12'(i), 1'b1);
      if (i == 5) pulse_req(3'd2);
    end
    exp_count++;
    idle(2);
    vectors++;
    if (freq_flag !== 3'd0) begin miscompares++; $display("FAIL mode_wait got %0d required 0", freq_flag); end
    send(1'b1, 1'b0, 12'h300, 1'b1);
    @(negedge clk);
    vectors++;
    if (freq_flag !== 3'd2) begin miscompares++; $display("FAIL mode_on_sop got %0d required 2", freq_flag); end
    idle(1);
    for (int i = 1; i < NB; i++) send(1'b0, i == NB - 1, 12'h300 + 12'(i), 1'b1);
    exp_count++;
    pulse_req(3'd5);
    send_frame(12'h400);
    exp_count++;
    idle(2);
    vectors++;
    if (freq_flag !== 3'd2) begin miscompares++; $display("FAIL mode_illegal got %0d required 2", freq_flag); end
    pulse_req(3'd0);
    send_frame(12'h500);
    exp_count++;
    idle(2);
    vectors += 2;
    if (freq_flag !== 3'd0) begin miscompares++; $display("FAIL mode_back0 got %0d required 0", freq_flag); end
    if (frame_count !== 16'(exp_count)) begin miscompares++; $display("FAIL mode_count got %0d required %0d", frame_count, exp_count); end
  endtask

  task automatic test_stall();
    stall_en = 1'b1;
    send_frame(12'h600);
    exp_count++;
    drain();
    stall_en = 1'b0;
    @(posedge clk);
    #2;
    src_ready = 1'b1;
    idle(2);
    vectors += 2;
    if (frame_count !== 16'(exp_count)) begin miscompares++; $display("FAIL stall_count got %0d required %0d", frame_count, exp_count); end
    if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL stall_err got %b required 0", err_sticky); end
  endtask

  task automatic test_errors();
    int d0;
    d0 = done_seen;
    // eop early at (0,1)
    for (int i = 0; i < 5; i++) send(i == 0, i == 4, 12'h700 + 12'(i), 1'b1);
    idle(2);
    vectors += 2;
    if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL early_eop_err got %b required 1", err_sticky); end
    if (frame_count !== 16'(exp_count)) begin miscompares++; $display("FAIL early_eop_count got %0d required %0d", frame_count, exp_count); end
    send(1'b0, 1'b0, 12'h7a0, 1'b0);
    send(1'b0, 1'b1, 12'h7a1, 1'b0);
    pulse_clr();
    vectors++;
    if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL err_clr got %b required 0", err_sticky); end
    // final position without eop
    for (int i = 0; i < NB; i++) send(i == 0, 1'b0, 12'h800 + 12'(i), 1'b1);
    send(1'b0, 1'b0, 12'h8ff, 1'b0);
    idle(1);
    vectors++;
    if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL no_eop_err got %b required 1", err_sticky); end
    pulse_clr();
    // sop+eop on a frame larger than 1x1
    send(1'b1, 1'b1, 12'h900, 1'b1);
    send(1'b0, 1'b0, 12'h901, 1'b0);
    idle(1);
    vectors += 2;
    if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL sop_eop_err got %b required 1", err_sticky); end
    if (dbg_state !== 1'b0) begin miscompares++; $display("FAIL sop_eop_state got %b required 0", dbg_state); end
    pulse_clr();
    // set and clear on the same edge: set wins
    err_clr = 1'b1;
    send(1'b1, 1'b0, 12'ha00, 1'b1);
    send(1'b0, 1'b1, 12'ha01, 1'b1);
    vectors++;
    if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL set_wins got %b required 1", err_sticky); end
    idle(1);
    err_clr = 1'b0;
    vectors += 2;
    if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL clr_after got %b required 0", err_sticky); end
    if (done_seen !== d0) begin miscompares++; $display("FAIL err_no_done got %0d required %0d", done_seen, d0); end
    drain();
  endtask

  task automatic test_restart();
    int d0;
    d0 = done_seen;
    for (int i = 0; i < 6; i++) send(i == 0, 1'b0, 12'hb00 + 12'(i), 1'b1);
    send(1'b1, 1'b0, 12'hc00, 1'b1);
    vectors++;
    if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL restart_err got %b required 1", err_sticky); end
    for (int i = 1; i < NB; i++) send(1'b0, i == NB - 1, 12'hc00 + 12'(i), 1'b1);
    exp_count++;
    idle(2);
    vectors += 2;
    if (done_seen - d0 !== 1) begin miscompares++; $display("FAIL restart_done got %0d required 1", done_seen - d0); end
    if (frame_count !== 16'(exp_count)) begin miscompares++; $display("FAIL restart_count got %0d required %0d", frame_count, exp_count); end
    pulse_clr();
  endtask

  task automatic test_auto();
    logic [2:0] seq [9];
    seq = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0, 3'd0, 3'd2};
    auto_en = 1'b1;
    for (int f = 0; f < 9; f++) begin
      send(1'b1, 1'b0, 12'hd00 + 12'(f * 16), 1'b1);
      @(negedge clk);
      vectors++;
      if (freq_flag !== seq[f]) begin miscompares++; $display("FAIL auto_seq frame=%0d got %0d required %0d", f, freq_flag, seq[f]); end
      idle(1);
      for (int i = 1; i < NB; i++) begin
        // frame 8 ends on an auto advance; the manual request must win
        if (f == 7 && i == NB - 1) begin
          req_flag  = 3'd2;
          req_valid = 1'b1;
        end
        send(1'b0, i == NB - 1, 12'hd00 + 12'(f * 16 + i), 1'b1);
        req_valid = 1'b0;
      end
      exp_count++;
      idle(2);
    end
    auto_en = 1'b0;
    vectors++;
    if (frame_count !== 16'(exp_count)) begin miscompares++; $display("FAIL auto_count got %0d required %0d", frame_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    int d0;
    for (int i = 0; i < 3; i++) send(i == 0, 1'b0, 12'he00 + 12'(i), 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_count = 0;
    vectors += 4;
    if (src_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b required 0", src_valid); end
    if (freq_flag !== 3'd0) begin miscompares++; $display("FAIL midrst_freq got %0d required 0", freq_flag); end
    if (frame_count !== 16'd0) begin miscompares++; $display("FAIL midrst_count got %0d required 0", frame_count); end
    if (dbg_state !== 1'b0 || err_sticky !== 1'b0) begin miscompares++; $display("FAIL midrst_state got %b%b required 00", dbg_state, err_sticky); end
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    for (int i = 3; i < NB; i++) send(1'b0, i == NB - 1, 12'he00 + 12'(i), 1'b0);
    d0 = done_seen;
    idle(1);
    vectors++;
    if (frame_count !== 16'd0) begin miscompares++; $display("FAIL midrst_drop got %0d required 0", frame_count); end
    send_frame(12'hf00);
    exp_count++;
    idle(2);
    vectors += 3;
    if (frame_count !== 16'(exp_count)) begin miscompares++; $display("FAIL midrst_next got %0d required %0d", frame_count, exp_count); end
    if (done_seen - d0 !== 1) begin miscompares++; $display("FAIL midrst_done got %0d required 1", done_seen - d0); end
    if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL midrst_err got %b required 0", err_sticky); end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_flag  = 3'd0;
    req_valid = 1'b0;
    auto_en   = 1'b0;
    err_clr   = 1'b0;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    snk_data  = 12'h000;
    src_ready = 1'b1;
    test_reset();
    test_frame();
    test_mode_req();
    test_stall();
    test_errors();
    test_restart();
    test_auto();
    test_reset_mid();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
